mos6502s_interrupt_sequencer: RTL and testbench

//  Sequences the program counter through reset, NMI, IRQ and BRK vector entry for the mos6502s core.

---
 rtl/mos6502s_interrupt_sequencer_if.sv | 33 +++
 rtl/mos6502s_interrupt_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_mos6502s_interrupt_sequencer.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mos6502s_interrupt_sequencer_if.sv
// Interface bundling the sequencer's core, memory-bus and PC-load signals.
// master = the sequencer itself; slave = core / bus mux / PC block side.
interface mos6502s_interrupt_sequencer_if;
    logic        rdy;
    logic        instr_bnd;
    logic        brk_req;
    logic        nmi_n;
    logic        irq_n;
    logic        i_flag;
    logic [15:0] pc_in;
    logic [7:0]  p_in;
    logic [7:0]  sp_in;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        sp_dec;
    logic        set_i;
    logic        pc_load;
    logic [15:0] pc_addr;
    logic        done;

    modport master (
        input  rdy, instr_bnd, brk_req, nmi_n, irq_n, i_flag, pc_in, p_in, sp_in, mem_rdata,
        output busy, mem_addr, mem_wdata, mem_we, sp_dec, set_i, pc_load, pc_addr, done
    );

    modport slave (
        output rdy, instr_bnd, brk_req, nmi_n, irq_n, i_flag, pc_in, p_in, sp_in, mem_rdata,
        input  busy, mem_addr, mem_wdata, mem_we, sp_dec, set_i, pc_load, pc_addr, done
    );
endinterface

// File: rtl/mos6502s_interrupt_sequencer.sv
// Reset/NMI/IRQ/BRK entry sequencer: pushes PCH, PCL, P to the stack page, fetches the
// vector and issues a one-cycle PC load.
module mos6502s_interrupt_sequencer #(
    parameter logic [15:0] NMI_VEC    = 16'hFFFA,
    parameter logic [15:0] RESET_VEC  = 16'hFFFC,
    parameter logic [15:0] IRQ_VEC    = 16'hFFFE,
    parameter logic [7:0]  STACK_PAGE = 8'h01
) (
    input logic                           clk,
    input logic                           rst,
    mos6502s_interrupt_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StPushH,
        StPushL,
        StPushP,
        StVecLo,
        StVecHi,
        StLoad
    } state_e;

    typedef enum logic [1:0] {
        SrcReset,
        SrcNmi,
        SrcIrq,
        SrcBrk
    } src_e;

    state_e      state_q, state_d;
    src_e        src_q, src_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] vec_q, vec_d;
    logic [7:0]  lo_q, lo_d;
    logic        nmi_n_q;
    logic        nmi_pend_q, nmi_pend_d;

    logic        nmi_fall;
    logic        nmi_clr;
    logic [15:0] vec_sel;
    logic        push_we;
    logic [7:0]  p_push;
    logic [15:0] stack_addr;

    // An IRQ/BRK already in flight is redirected to the NMI vector if an NMI is pending.
    always_comb begin
        if (src_q == SrcNmi) begin
            vec_sel = NMI_VEC;
        end else if ((src_q == SrcIrq || src_q == SrcBrk) && nmi_pend_q) begin
            vec_sel = NMI_VEC;
        end else if (src_q == SrcReset) begin
            vec_sel = RESET_VEC;
        end else begin
            vec_sel = IRQ_VEC;
        end
    end

    assign nmi_fall   = nmi_n_q & ~bus.nmi_n;
    assign nmi_clr    = bus.rdy && (state_q == StPushP) && (vec_sel == NMI_VEC);
    // A fresh edge in the clear cycle wins, so that NMI is not lost.
    assign nmi_pend_d = nmi_fall | (nmi_pend_q & ~nmi_clr);

    // Reset walks the push states as dummy cycles: SP still drops by three, nothing is written.
    assign push_we    = (src_q != SrcReset);
    assign p_push     = {bus.p_in[7:6], 1'b1, (src_q == SrcBrk), bus.p_in[3:0]};
    assign stack_addr = {STACK_PAGE, bus.sp_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StPushH;
            src_q      <= SrcReset;
            pc_q       <= 16'h0000;
            vec_q      <= 16'h0000;
            lo_q       <= 8'h00;
            nmi_n_q    <= 1'b1;
            nmi_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            pc_q       <= pc_d;
            vec_q      <= vec_d;
            lo_q       <= lo_d;
            nmi_n_q    <= bus.nmi_n;
            nmi_pend_q <= nmi_pend_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        pc_d          = pc_q;
        vec_d         = vec_q;
        lo_d          = lo_q;
        bus.busy      = (state_q != StIdle);
        bus.mem_addr  = 16'h0000;
        bus.mem_wdata = 8'h00;
        bus.mem_we    = 1'b0;
        bus.sp_dec    = 1'b0;
        bus.set_i     = 1'b0;
        bus.pc_load   = 1'b0;
        bus.pc_addr   = 16'h0000;
        bus.done      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.instr_bnd && bus.rdy) begin
                    if (nmi_pend_q) begin
                        src_d   = SrcNmi;
                        pc_d    = bus.pc_in;
                        state_d = StPushH;
                    end else if (!bus.irq_n && !bus.i_flag) begin
                        src_d   = SrcIrq;
                        pc_d    = bus.pc_in;
                        state_d = StPushH;
                    end else if (bus.brk_req) begin
                        src_d   = SrcBrk;
                        pc_d    = bus.pc_in;
                        state_d = StPushH;
                    end
                end
            end
            StPushH: begin
                bus.mem_addr  = stack_addr;
                bus.sp_dec    = 1'b1;
                bus.mem_we    = push_we;
                bus.mem_wdata = push_we ? pc_q[15:8] : 8'h00;
                if (bus.rdy) state_d = StPushL;
            end
            StPushL: begin
                bus.mem_addr  = stack_addr;
                bus.sp_dec    = 1'b1;
                bus.mem_we    = push_we;
                bus.mem_wdata = push_we ? pc_q[7:0] : 8'h00;
                if (bus.rdy) state_d = StPushP;
            end
            StPushP: begin
                bus.mem_addr  = stack_addr;
                bus.sp_dec    = 1'b1;
                bus.mem_we    = push_we;
                bus.mem_wdata = push_we ? p_push : 8'h00;
                if (bus.rdy) begin
                    vec_d   = vec_sel;
                    state_d = StVecLo;
                end
            end
            StVecLo: begin
                bus.mem_addr = vec_q;
                bus.set_i    = 1'b1;
                if (bus.rdy) state_d = StVecHi;
            end
            StVecHi: begin
                bus.mem_addr = vec_q + 16'd1;
                if (bus.rdy) begin
                    lo_d    = bus.mem_rdata;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                bus.pc_load = 1'b1;
                bus.done    = 1'b1;
                bus.pc_addr = {bus.mem_rdata, lo_q};
                if (bus.rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // While rst is held, only busy is visible so no partial push or load escapes.
        if (rst) begin
            bus.busy      = 1'b1;
            bus.mem_addr  = 16'h0000;
            bus.mem_wdata = 8'h00;
            bus.mem_we    = 1'b0;
            bus.sp_dec    = 1'b0;
            bus.set_i     = 1'b0;
            bus.pc_load   = 1'b0;
            bus.pc_addr   = 16'h0000;
            bus.done      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mos6502s_interrupt_sequencer.sv
// Self-checking bench: bus-level monitor plus a transaction model of vector entry.
module tb_mos6502s_interrupt_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mos6502s_interrupt_sequencer_if bus();

    mos6502s_interrupt_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] sp_base = 8'hFF;
    logic [7:0] dec_cnt = 8'h00;
    int         tot_dec = 0;

    assign bus.sp_in = sp_base - dec_cnt;

    // Memory returns read data one cycle after the address; a stalled bus holds it.
    always @(posedge clk) begin
        if (bus.rdy === 1'b1) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.sp_dec === 1'b1 && bus.rdy === 1'b1) begin
            dec_cnt <= dec_cnt + 8'd1;
            tot_dec <= tot_dec + 1;
        end
    end

    int          cyc = 0, rcnt = 0, busy_cnt = 0, act_cnt = 0, done_bad = 0;
    logic [23:0] wq[$];
    logic [15:0] vq[$];
    logic [15:0] rq[$];
    logic [15:0] pcq[$];
    int          lq[$];
    int          lcq[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.rdy === 1'b1) begin
            rcnt <= rcnt + 1;
            if (bus.mem_we === 1'b1) wq.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.set_i === 1'b1) vq.push_back(bus.mem_addr);
            if (bus.busy === 1'b1 && bus.mem_we === 1'b0 && bus.sp_dec === 1'b0 &&
                bus.pc_load === 1'b0 && rst === 1'b0) rq.push_back(bus.mem_addr);
            if (bus.pc_load === 1'b1) begin
                pcq.push_back(bus.pc_addr);
                lq.push_back(rcnt + 1);
                lcq.push_back(cyc + 1);
            end
        end
        if (bus.busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if ((bus.mem_we | bus.sp_dec | bus.set_i | bus.pc_load) === 1'b1) act_cnt <= act_cnt + 1;
        if (bus.done !== bus.pc_load) done_bad <= done_bad + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_load(input int n_before, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (pcq.size() > n_before) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (pcq.size() > n_before) ok = 1'b1;
    endtask

    task automatic test_reset();
        int r0, n0, w0, v0, q0, d0;
        bit ok;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++; $display("FAIL rst_busy got=%b exp=1", bus.busy);
        end
        checks++;
        if ({bus.mem_we, bus.sp_dec, bus.set_i, bus.pc_load, bus.done} !== 5'b0) begin
            failures++;
            $display("FAIL rst_strobes got=%b exp=00000",
                     {bus.mem_we, bus.sp_dec, bus.set_i, bus.pc_load, bus.done});
        end
        checks++;
        if (bus.mem_addr !== 16'h0000) begin
            failures++; $display("FAIL rst_addr got=%h exp=0000", bus.mem_addr);
        end
        r0 = rcnt; n0 = pcq.size(); w0 = wq.size(); v0 = vq.size(); q0 = rq.size(); d0 = tot_dec;
        rst = 1'b0;
        wait_load(n0, 40, ok);
        checks++;
        if (!ok) begin
            failures++; $display("FAIL rst_seq_timeout got=no_load exp=load");
        end
        checks++;
        if (pcq[n0] !== 16'h8000) begin
            failures++; $display("FAIL rst_pc got=%h exp=8000", pcq[n0]);
        end
        checks++;
        if (lq[n0] !== r0 + 6) begin
            failures++; $display("FAIL rst_latency got=%0d exp=%0d", lq[n0] - r0, 6);
        end
        tick();
        checks++;
        if (tot_dec - d0 !== 3) begin
            failures++; $display("FAIL rst_sp_dec got=%0d exp=3", tot_dec - d0);
        end
        checks++;
        if (wq.size() - w0 !== 0) begin
            failures++; $display("FAIL rst_writes got=%0d exp=0", wq.size() - w0);
        end
        checks++;
        if (rq[q0] !== 16'hFFFC || rq[q0+1] !== 16'hFFFD) begin
            failures++; $display("FAIL rst_reads got=%h,%h exp=fffc,fffd", rq[q0], rq[q0+1]);
        end
        checks++;
        if (vq[v0] !== 16'hFFFC) begin
            failures++; $display("FAIL rst_set_i got=%h exp=fffc", vq[v0]);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL rst_idle got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_irq();
        int n0, w0, v0, q0, d0, acc;
        logic [15:0] pc_exp;
        bit ok;
        mem[16'hFFFE] = 8'($urandom);
        mem[16'hFFFF] = 8'($urandom);
        pc_exp = {mem[16'hFFFF], mem[16'hFFFE]};
        bus.pc_in = 16'h1234; bus.p_in = 8'h00; sp_base = 8'hFD + dec_cnt;
        bus.i_flag = 1'b0; bus.irq_n = 1'b0; bus.instr_bnd = 1'b1;
        n0 = pcq.size(); w0 = wq.size(); v0 = vq.size(); q0 = rq.size(); d0 = tot_dec;
        tick();
        acc = rcnt;
        bus.instr_bnd = 1'b0; bus.irq_n = 1'b1;
        wait_load(n0, 40, ok);
        tick();
        checks++;
        if (!ok) begin
            failures++; $display("FAIL irq_timeout got=no_load exp=load");
        end
        checks++;
        if (wq.size() - w0 !== 3) begin
            failures++; $display("FAIL irq_nwrites got=%0d exp=3", wq.size() - w0);
        end
        checks++;
        if (wq[w0] !== 24'h01FD12) begin
            failures++; $display("FAIL irq_push_h got=%h exp=01fd12", wq[w0]);
        end
        checks++;
        if (wq[w0+1] !== 24'h01FC34) begin
            failures++; $display("FAIL irq_push_l got=%h exp=01fc34", wq[w0+1]);
        end
        checks++;
        if (wq[w0+2] !== 24'h01FB20) begin
            failures++; $display("FAIL irq_push_p got=%h exp=01fb20", wq[w0+2]);
        end
        checks++;
        if (vq[v0] !== 16'hFFFE) begin
            failures++; $display("FAIL irq_vec got=%h exp=fffe", vq[v0]);
        end
        checks++;
        if (rq[q0] !== 16'hFFFE || rq[q0+1] !== 16'hFFFF) begin
            failures++; $display("FAIL irq_reads got=%h,%h exp=fffe,ffff", rq[q0], rq[q0+1]);
        end
        checks++;
        if (pcq[n0] !== pc_exp) begin
            failures++; $display("FAIL irq_pc got=%h exp=%h", pcq[n0], pc_exp);
        end
        checks++;
        if (lq[n0] !== acc + 6) begin
            failures++; $display("FAIL irq_latency got=%0d exp=6", lq[n0] - acc);
        end
        checks++;
        if (tot_dec - d0 !== 3 || bus.sp_in !== 8'hFA) begin
            failures++; $display("FAIL irq_sp got=%0d/%h exp=3/fa", tot_dec - d0, bus.sp_in);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL irq_idle got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_masked();
        int b0, a0, n0;
        bus.i_flag = 1'b1; bus.irq_n = 1'b0; bus.brk_req = 1'b0; bus.instr_bnd = 1'b1;
        b0 = busy_cnt; a0 = act_cnt; n0 = pcq.size();
        repeat (20) tick();
        checks++;
        if (busy_cnt - b0 !== 0) begin
            failures++; $display("FAIL masked_busy got=%0d exp=0", busy_cnt - b0);
        end
        checks++;
        if (act_cnt - a0 !== 0) begin
            failures++; $display("FAIL masked_bus got=%0d exp=0", act_cnt - a0);
        end
        checks++;
        if (pcq.size() !== n0) begin
            failures++; $display("FAIL masked_load got=%0d exp=%0d", pcq.size(), n0);
        end
        bus.irq_n = 1'b1; bus.instr_bnd = 1'b0;
    endtask

    task automatic test_brk_hijack();
        int n0, w0, v0, b0;
        logic [7:0] sp, p, p_exp, s2;
        logic [15:0] pc_exp;
        bit ok;
        sp = 8'($urandom); p = 8'($urandom);
        s2 = sp - 8'd2;
        p_exp = (p & 8'hEF) | 8'h30;
        mem[16'hFFFA] = 8'($urandom);
        mem[16'hFFFB] = 8'($urandom);
        pc_exp = {mem[16'hFFFB], mem[16'hFFFA]};
        bus.pc_in = 16'($urandom); bus.p_in = p; sp_base = sp + dec_cnt;
        bus.i_flag = 1'($urandom); bus.irq_n = 1'b1; bus.brk_req = 1'b1; bus.instr_bnd = 1'b1;
        n0 = pcq.size(); w0 = wq.size(); v0 = vq.size();
        tick();
        bus.brk_req = 1'b0; bus.instr_bnd = 1'b0;
        tick();
        bus.nmi_n = 1'b0;
        wait_load(n0, 40, ok);
        tick();
        checks++;
        if (!ok) begin
            failures++; $display("FAIL brk_timeout got=no_load exp=load");
        end
        checks++;
        if (wq[w0+2] !== {8'h01, s2, p_exp}) begin
            failures++; $display("FAIL brk_push_p got=%h exp=%h", wq[w0+2], {8'h01, s2, p_exp});
        end
        checks++;
        if (vq[v0] !== 16'hFFFA) begin
            failures++; $display("FAIL brk_hijack_vec got=%h exp=fffa", vq[v0]);
        end
        checks++;
        if (pcq[n0] !== pc_exp) begin
            failures++; $display("FAIL brk_pc got=%h exp=%h", pcq[n0], pc_exp);
        end
        // nmi_n stays low: the consumed edge must not produce a second entry.
        bus.instr_bnd = 1'b1;
        b0 = busy_cnt;
        repeat (20) tick();
        checks++;
        if (pcq.size() !== n0 + 1 || busy_cnt - b0 !== 0) begin
            failures++;
            $display("FAIL brk_no_second_nmi got=%0d loads/%0d busy exp=1/0",
                     pcq.size() - n0, busy_cnt - b0);
        end
        bus.instr_bnd = 1'b0;
        bus.nmi_n = 1'b1;
        tick();
    endtask

    task automatic test_stall();
        int n0, acc, acc_cyc;
        logic [15:0] pc_exp;
        bit ok;
        mem[16'hFFFE] = 8'($urandom);
        mem[16'hFFFF] = 8'($urandom);
        pc_exp = {mem[16'hFFFF], mem[16'hFFFE]};
        bus.pc_in = 16'($urandom); bus.p_in = 8'($urandom); sp_base = 8'($urandom);
        bus.i_flag = 1'b0; bus.irq_n = 1'b0; bus.instr_bnd = 1'b1;
        n0 = pcq.size();
        tick();
        acc = rcnt; acc_cyc = cyc;
        bus.instr_bnd = 1'b0; bus.irq_n = 1'b1;
        repeat (4) tick();
        bus.rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.mem_addr !== 16'hFFFF || bus.pc_load !== 1'b0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold got=%h/%b/%b exp=ffff/0/1",
                         bus.mem_addr, bus.pc_load, bus.busy);
            end
            tick();
        end
        bus.rdy = 1'b1;
        wait_load(n0, 40, ok);
        tick();
        checks++;
        if (!ok) begin
            failures++; $display("FAIL stall_timeout got=no_load exp=load");
        end
        checks++;
        if (pcq[n0] !== pc_exp) begin
            failures++; $display("FAIL stall_pc got=%h exp=%h", pcq[n0], pc_exp);
        end
        checks++;
        if (lcq[n0] !== acc_cyc + 9) begin
            failures++; $display("FAIL stall_cycle got=%0d exp=9", lcq[n0] - acc_cyc);
        end
        checks++;
        if (lq[n0] !== acc + 6) begin
            failures++; $display("FAIL stall_rdy_cycles got=%0d exp=6", lq[n0] - acc);
        end
    endtask

    task automatic test_rst_mid();
        int n0, w0, d0, r0;
        logic [15:0] pc_exp;
        bit ok;
        mem[16'hFFFC] = 8'($urandom);
        mem[16'hFFFD] = 8'($urandom);
        pc_exp = {mem[16'hFFFD], mem[16'hFFFC]};
        bus.pc_in = 16'($urandom); bus.p_in = 8'($urandom); sp_base = 8'($urandom);
        bus.i_flag = 1'b0; bus.irq_n = 1'b0; bus.instr_bnd = 1'b1;
        n0 = pcq.size(); w0 = wq.size(); d0 = tot_dec;
        tick();
        bus.instr_bnd = 1'b0; bus.irq_n = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b1 || bus.mem_we !== 1'b0 || bus.sp_dec !== 1'b0 ||
            bus.mem_addr !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_outputs got=%b/%b/%b/%h exp=1/0/0/0000",
                     bus.busy, bus.mem_we, bus.sp_dec, bus.mem_addr);
        end
        tick();
        rst = 1'b0;
        r0 = rcnt;
        wait_load(n0, 40, ok);
        tick();
        tick();
        checks++;
        if (!ok || pcq.size() !== n0 + 1) begin
            failures++; $display("FAIL rstmid_loads got=%0d exp=1", pcq.size() - n0);
        end
        checks++;
        if (pcq[n0] !== pc_exp) begin
            failures++; $display("FAIL rstmid_pc got=%h exp=%h", pcq[n0], pc_exp);
        end
        checks++;
        if (lq[n0] !== r0 + 6) begin
            failures++; $display("FAIL rstmid_latency got=%0d exp=6", lq[n0] - r0);
        end
        checks++;
        if (wq.size() - w0 !== 2) begin
            failures++; $display("FAIL rstmid_writes got=%0d exp=2", wq.size() - w0);
        end
        checks++;
        if (tot_dec - d0 !== 5) begin
            failures++; $display("FAIL rstmid_sp_dec got=%0d exp=5", tot_dec - d0);
        end
    endtask

    task automatic test_random();
        logic [15:0] pc, vec, pc_exp;
        logic [7:0]  p, sp, s1, s2, p_exp;
        bit          pre_nmi, irq_on, imask, brk, ok;
        int          kind, n0, w0, v0, a0, acc;
        for (int it = 0; it < 40; it++) begin
            pc = 16'($urandom); p = 8'($urandom); sp = 8'($urandom);
            for (int a = 16'hFFFA; a <= 16'hFFFF; a++) mem[a] = 8'($urandom);
            pre_nmi = ($urandom_range(0, 4) == 0);
            irq_on = 1'($urandom); imask = 1'($urandom); brk = 1'($urandom);
            if (pre_nmi) begin
                bus.nmi_n = 1'b0;
                tick();
                tick();
                bus.nmi_n = 1'b1;
                tick();
            end
            // kind: 0 none, 1 NMI, 2 IRQ, 3 BRK
            if (pre_nmi) kind = 1;
            else if (irq_on && !imask) kind = 2;
            else if (brk) kind = 3;
            else kind = 0;
            bus.pc_in = pc; bus.p_in = p; sp_base = sp + dec_cnt;
            bus.irq_n = ~irq_on; bus.i_flag = imask; bus.brk_req = brk; bus.instr_bnd = 1'b1;
            if (kind == 0) begin
                a0 = act_cnt; n0 = pcq.size();
                repeat (5) tick();
                checks++;
                if (act_cnt - a0 !== 0 || pcq.size() !== n0) begin
                    failures++;
                    $display("FAIL rnd%0d_idle got=%0d exp=0", it, act_cnt - a0);
                end
                bus.instr_bnd = 1'b0; bus.brk_req = 1'b0; bus.irq_n = 1'b1;
                continue;
            end
            vec = (kind == 1) ? 16'hFFFA : 16'hFFFE;
            pc_exp = {mem[vec + 16'd1], mem[vec]};
            s1 = sp - 8'd1; s2 = sp - 8'd2;
            p_exp = (p & 8'hEF) | 8'h20 | ((kind == 3) ? 8'h10 : 8'h00);
            n0 = pcq.size(); w0 = wq.size(); v0 = vq.size();
            tick();
            acc = rcnt;
            bus.instr_bnd = 1'b0; bus.brk_req = 1'b0; bus.irq_n = 1'b1;
            ok = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (pcq.size() > n0) begin
                    ok = 1'b1;
                    break;
                end
                bus.rdy = ($urandom_range(0, 3) != 0);
                tick();
            end
            bus.rdy = 1'b1;
            tick();
            checks++;
            if (!ok) begin
                failures++; $display("FAIL rnd%0d_timeout got=no_load exp=load", it);
            end
            checks++;
            if (wq[w0] !== {8'h01, sp, pc[15:8]} || wq[w0+1] !== {8'h01, s1, pc[7:0]}) begin
                failures++;
                $display("FAIL rnd%0d_push_pc got=%h,%h exp=%h,%h", it, wq[w0], wq[w0+1],
                         {8'h01, sp, pc[15:8]}, {8'h01, s1, pc[7:0]});
            end
            checks++;
            if (wq[w0+2] !== {8'h01, s2, p_exp}) begin
                failures++;
                $display("FAIL rnd%0d_push_p got=%h exp=%h", it, wq[w0+2], {8'h01, s2, p_exp});
            end
            checks++;
            if (vq[v0] !== vec) begin
                failures++; $display("FAIL rnd%0d_vec got=%h exp=%h", it, vq[v0], vec);
            end
            checks++;
            if (pcq[n0] !== pc_exp || lq[n0] !== acc + 6) begin
                failures++;
                $display("FAIL rnd%0d_load got=%h@%0d exp=%h@6", it, pcq[n0], lq[n0] - acc, pc_exp);
            end
            checks++;
            if (bus.busy !== 1'b0) begin
                failures++; $display("FAIL rnd%0d_idle_after got=%b exp=0", it, bus.busy);
            end
        end
    endtask

    task automatic test_done_pulse();
        checks++;
        if (done_bad !== 0) begin
            failures++; $display("FAIL done_with_pc_load got=%0d exp=0", done_bad);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        bus.rdy = 1'b1; bus.instr_bnd = 1'b0; bus.brk_req = 1'b0; bus.nmi_n = 1'b1;
        bus.irq_n = 1'b1; bus.i_flag = 1'b1; bus.pc_in = 16'h0000; bus.p_in = 8'h00;
        bus.mem_rdata = 8'h00;
        test_reset();
        test_irq();
        test_masked();
        test_brk_hijack();
        test_stall();
        test_rst_mid();
        test_random();
        test_done_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
